// File: rtl/vec_bank_mem_responder_if.sv
// Request/response bus between the vector pipeline (master) and the banked
// memory responder (slave).
interface vec_bank_mem_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_is_store;
  logic [15:0]  req_addr;
  logic [4:0]   req_len;
  logic [255:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_is_store, req_addr, req_len, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_len, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/vec_bank_mem_responder.sv
// Vector load/store responder: spreads up to 16 elements over four
// word-interleaved 16-bit banks, four elements per beat, one request at a time.
module vec_bank_mem_responder #(
  parameter int DEPTH = 1024
) (
  input logic                     clk,
  input logic                     rst_n,
  vec_bank_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_RESP} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_is_store;
  logic [15:0]  r_addr;
  logic [4:0]   r_len;
  logic [255:0] r_wdata;
  logic [255:0] r_gather;
  logic         r_err;
  logic [1:0]   r_beat;
  logic [3:0]   r_rd_en;
  logic [3:0]   r_rd_elem [4];
  logic [15:0]  r_bank_q  [4];
  logic [15:0]  r_mem     [4][DEPTH];

  logic         w_req_fire;
  logic         w_resp_fire;
  logic         w_len_ok;
  logic         w_last_beat;
  logic [4:0]   w_len_m1;
  logic [1:0]   w_off       [4];
  logic [3:0]   w_elem      [4];
  logic [15:0]  w_lane_addr [4];
  logic [AW-1:0] w_row      [4];
  logic [3:0]   w_lane_en;

  assign w_req_fire  = bus.req_valid && (r_state == S_IDLE);
  assign w_resp_fire = bus.resp_ready && (r_state == S_RESP);
  assign w_len_ok    = (bus.req_len != 5'd0) && (bus.req_len <= 5'd16);
  assign w_len_m1    = r_len - 5'd1;
  assign w_last_beat = (r_beat == w_len_m1[3:2]);

  // Each bank serves exactly one element of the beat: the one whose address
  // low bits equal the bank index, so lane offset = bank - base[1:0].
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_off[b]       = 2'(b) - r_addr[1:0];
      w_elem[b]      = {r_beat, w_off[b]};
      w_lane_addr[b] = r_addr + {12'd0, w_elem[b]};
      w_row[b]       = AW'(w_lane_addr[b] >> 2);
      w_lane_en[b]   = (r_state == S_BUSY) && ({1'b0, w_elem[b]} < r_len);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_fire) w_next = w_len_ok ? S_BUSY : S_RESP;
      S_BUSY:  if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN: w_next = S_RESP;
      S_RESP:  if (w_resp_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_wdata    <= '0;
      r_gather   <= '0;
      r_err      <= 1'b0;
      r_beat     <= '0;
      r_rd_en    <= '0;
      for (int b = 0; b < 4; b++) r_rd_elem[b] <= '0;
    end else begin
      if (w_req_fire) begin
        r_is_store <= bus.req_is_store;
        r_addr     <= bus.req_addr;
        r_len      <= bus.req_len;
        r_wdata    <= bus.req_wdata;
        r_gather   <= '0;
        r_err      <= !w_len_ok;
        r_beat     <= '0;
      end else if (r_state == S_BUSY) begin
        r_beat <= r_beat + 2'd1;
      end
      // Bank reads return one cycle later; remember which slot each belongs to.
      for (int b = 0; b < 4; b++) begin
        r_rd_en[b]   <= w_lane_en[b] && !r_is_store;
        r_rd_elem[b] <= w_elem[b];
        if (r_rd_en[b]) r_gather[16*r_rd_elem[b] +: 16] <= r_bank_q[b];
      end
    end
  end

  // NOTE: bank storage and read ports carry no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_lane_en[b] && r_is_store) r_mem[b][w_row[b]] <= r_wdata[16*w_elem[b] +: 16];
      if (w_lane_en[b] && !r_is_store) r_bank_q[b] <= r_mem[b][w_row[b]];
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_gather;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_vec_bank_mem_responder.sv
// Directed bench for vec_bank_mem_responder: latency, data, wrap, illegal
// lengths, backpressure and mid-operation reset.
module tb_vec_bank_mem_responder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vec_bank_mem_responder_if bus();

  vec_bank_mem_responder #(.DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ramp(input logic [15:0] base, input int n);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[16*i +: 16] = base + 16'(i);
    return v;
  endfunction

  // One full transaction: request, count edges until resp_valid, optional
  // backpressure with a competing request, then response handshake.
  task automatic xfer(input logic st, input logic [15:0] addr, input logic [4:0] len,
                      input logic [255:0] wdata, input int hold,
                      output logic [255:0] rdata, output logic err, output int cycles);
    logic [255:0] held;
    check("acc_ready", bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_addr     = addr;
    bus.req_len      = len;
    bus.req_wdata    = wdata;
    cycles = 0;
    rdata  = '0;
    err    = 1'b0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b1;
        bus.req_addr     = 16'($urandom);
        bus.req_len      = 5'($urandom);
        bus.req_wdata    = {8{$urandom}};
      end
    end while (!bus.resp_valid && cycles < 40);
    if (!bus.resp_valid) begin
      $display("FAIL timeout: no response after %0d cycles", cycles);
      n_checks++;
      n_errors++;
      cycles = -1;
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    held  = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b1;
      bus.req_addr     = 16'h0040;
      bus.req_len      = 5'd4;
      bus.req_wdata    = {16{16'h5555}};
      @(posedge clk); #1;
      check("bp_valid", bus.resp_valid, 1'b1);
      check("bp_rdata", bus.resp_rdata, held);
      check("bp_req_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 1'b0);
  endtask

  initial begin
    logic [255:0] rd;
    logic [255:0] exp;
    logic [255:0] wd;
    logic         er;
    int           cyc;
    n_checks = 0;
    n_errors = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_addr     = '0;
    bus.req_len      = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_rdata", bus.resp_rdata, '0);
    check("rst_err", bus.resp_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-length store and load-back
    xfer(1'b1, 16'h0000, 5'd16, ramp(16'h1000, 16), 0, rd, er, cyc);
    check("st16_lat", cyc, 6);
    check("st16_rdata", rd, '0);
    check("st16_err", er, 1'b0);
    xfer(1'b0, 16'h0000, 5'd16, '0, 0, rd, er, cyc);
    check("ld16_lat", cyc, 6);
    check("ld16_rdata", rd, ramp(16'h1000, 16));

    // Misaligned store with junk beyond len, then misaligned load
    wd = ramp(16'hA003, 5);
    for (int i = 5; i < 16; i++) wd[16*i +: 16] = 16'hDEAD;
    xfer(1'b1, 16'h0003, 5'd5, wd, 0, rd, er, cyc);
    check("st5_lat", cyc, 4);
    xfer(1'b0, 16'h0003, 5'd5, '0, 0, rd, er, cyc);
    check("ld5_lat", cyc, 4);
    check("ld5_rdata", rd, ramp(16'hA003, 5));
    exp = ramp(16'h1000, 16);
    for (int i = 3; i < 8; i++) exp[16*i +: 16] = 16'hA000 + 16'(i);
    xfer(1'b0, 16'h0000, 5'd16, '0, 0, rd, er, cyc);
    check("ld16_mask", rd, exp);

    // Address wrap 0xFFFF -> 0x0000
    xfer(1'b1, 16'hFFFE, 5'd4, ramp(16'h0001, 4), 0, rd, er, cyc);
    check("wrap_st_lat", cyc, 3);
    xfer(1'b0, 16'hFFFE, 5'd1, '0, 0, rd, er, cyc);
    check("wrap_fffe", rd, 256'h1);
    xfer(1'b0, 16'hFFFF, 5'd1, '0, 0, rd, er, cyc);
    check("wrap_ffff", rd, 256'h2);
    xfer(1'b0, 16'h0000, 5'd1, '0, 0, rd, er, cyc);
    check("wrap_0000", rd, 256'h3);
    xfer(1'b0, 16'h0001, 5'd1, '0, 0, rd, er, cyc);
    check("wrap_0001", rd, 256'h4);
    check("wrap_lat", cyc, 3);

    // Illegal lengths leave memory untouched
    xfer(1'b1, 16'h0040, 5'd4, ramp(16'h4040, 4), 0, rd, er, cyc);
    xfer(1'b1, 16'h0040, 5'd0, {16{16'hFFFF}}, 0, rd, er, cyc);
    check("len0_lat", cyc, 1);
    check("len0_err", er, 1'b1);
    check("len0_rdata", rd, '0);
    xfer(1'b1, 16'h0040, 5'd17, {16{16'hFFFF}}, 0, rd, er, cyc);
    check("len17_lat", cyc, 1);
    check("len17_err", er, 1'b1);

    // Backpressure with a competing store request held during RESP
    xfer(1'b0, 16'h0040, 5'd4, '0, 3, rd, er, cyc);
    check("bp_ld_rdata", rd, ramp(16'h4040, 4));
    check("bp_ld_err", er, 1'b0);
    xfer(1'b0, 16'h0040, 5'd4, '0, 0, rd, er, cyc);
    check("bp_no_write", rd, ramp(16'h4040, 4));

    // Reset during beat 1 of a full store
    xfer(1'b1, 16'h0200, 5'd16, ramp(16'h2200, 16), 0, rd, er, cyc);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_addr     = 16'h0200;
    bus.req_len      = 5'd16;
    bus.req_wdata    = {16{16'hBEEF}};
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_resp_valid", bus.resp_valid, 1'b0);
    check("mid_rst_err", bus.resp_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_resp", bus.resp_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp = ramp(16'h2200, 16);
    for (int i = 0; i < 4; i++) exp[16*i +: 16] = 16'hBEEF;
    xfer(1'b0, 16'h0200, 5'd16, '0, 0, rd, er, cyc);
    check("mid_rst_partial", rd, exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
